// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with a mid-bit sampling counter.
// Ports:
//   clk        - system clock
//   rstb       - asynchronous active-low reset
//   rx         - serial line, idle high, asynchronous to clk
//   UART_msg   - last correctly framed data word, LSB received first
//   UART_valid - one-cycle pulse when UART_msg is updated
//   UART_err   - one-cycle pulse when the stop bit is sampled low
//   UART_busy  - high while a frame is being received
module uart_rx #(
  parameter int unsigned C_CLK_FRQ         = 100_000_000,
  parameter int unsigned C_UART_RATE       = 115200,
  parameter int unsigned C_UART_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         rx,
  output logic [C_UART_DATA_WIDTH-1:0] UART_msg,
  output logic                         UART_valid,
  output logic                         UART_err,
  output logic                         UART_busy
);

  localparam int unsigned C_BIT  = C_CLK_FRQ / C_UART_RATE;
  localparam int unsigned C_HALF = C_BIT / 2;
  localparam int unsigned CNT_W  = $clog2(C_BIT);
  localparam int unsigned DW     = C_UART_DATA_WIDTH;
  localparam int unsigned IDX_W  = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Too few clocks per bit to place a half-bit sample point.
  if (C_BIT < 4) begin : g_bit_check
    $error("uart_rx: C_CLK_FRQ / C_UART_RATE must be at least 4");
  end

  logic [1:0]       sync;
  logic [1:0]       sync_fill;
  logic             rxs;
  logic             rxs_d;
  logic             armed;
  logic             armed_n;
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_n;
  logic [DW-1:0]    sh;
  logic [DW-1:0]    sh_n;
  logic [DW-1:0]    msg_n;
  logic             valid_n;
  logic             err_n;
  logic             busy_n;

  assign rxs = sync[1];

  // Two-flop synchronizer; sync_fill marks when rxs carries a real line sample
  // rather than the reset value, so a line held low through reset never arms.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync      <= 2'b11;
      sync_fill <= 2'b00;
      rxs_d     <= 1'b1;
    end else begin
      sync      <= {sync[0], rx};
      sync_fill <= {sync_fill[0], 1'b1};
      rxs_d     <= rxs;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      UART_msg   <= '0;
      UART_valid <= 1'b0;
      UART_err   <= 1'b0;
      UART_busy  <= 1'b0;
    end else begin
      state      <= state_n;
      armed      <= armed_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      UART_msg   <= msg_n;
      UART_valid <= valid_n;
      UART_err   <= err_n;
      UART_busy  <= busy_n;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    msg_n   = UART_msg;
    valid_n = 1'b0;
    err_n   = 1'b0;
    // A start edge is only trusted once the line has been seen high for real.
    armed_n = armed | (sync_fill[1] & rxs);

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (armed && rxs_d && !rxs) begin
          state_n = S_START;
        end
      end

      S_START: begin
        if (cnt == CNT_W'(C_HALF - 1)) begin
          cnt_n   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_n = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt == CNT_W'(C_BIT - 1)) begin
          cnt_n = '0;
          sh_n  = DW'({rxs, sh} >> 1);
          idx_n = idx + 1'b1;
          if (idx == IDX_W'(DW - 1)) begin
            state_n = S_STOP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == CNT_W'(C_BIT - 1)) begin
          cnt_n = '0;
          // Leave mid stop bit so a back-to-back start edge is not missed.
          state_n = S_IDLE;
          if (rxs) begin
            msg_n   = sh;
            valid_n = 1'b1;
          end else begin
            err_n   = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule
